// File: rtl/cpu_program_feeder.sv
// Host-side instruction feeder for the 8-bit CPU: presents opcode then immediate
// bytes from a host-loaded 64x16 program memory and follows the CPU's pc.
module cpu_program_feeder #(
    parameter int OPC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  halt_addr,
    input  logic        prog_we,
    input  logic [5:0]  prog_addr,
    input  logic [15:0] prog_data,
    input  logic [7:0]  cpu_status,
    output logic [7:0]  cpu_ui,
    output logic        busy,
    output logic        halted,
    output logic        proto_err,
    output logic [7:0]  fetch_count,
    output logic [7:0]  invalid_count,
    output logic [5:0]  cur_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_IMM,
        S_SETTLE,
        S_HALT
    } state_e;

    localparam logic [3:0] OPC_LAST = 4'(OPC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cpu_ui_q, cpu_ui_d;
    logic [5:0]  cur_addr_q, cur_addr_d;
    logic [3:0]  opc_cnt_q, opc_cnt_d;
    logic        send_ins_q;
    logic        proto_err_q, proto_err_d;
    logic [7:0]  fetch_count_q, fetch_count_d;
    logic [7:0]  invalid_count_q, invalid_count_d;
    logic [15:0] mem_q [64];

    logic       send_ins;
    logic       invalid_ins;
    logic [5:0] pc;
    logic       req;

    assign send_ins    = cpu_status[7];
    assign invalid_ins = cpu_status[6];
    assign pc          = cpu_status[5:0];
    assign req         = send_ins & ~send_ins_q;

    assign busy = (state_q == S_OPC) || (state_q == S_IMM) || (state_q == S_SETTLE);

    // NOTE: program storage carries no reset; the host is responsible for loading
    // every address it intends to run before raising run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so that no
        // branch below can leave one unassigned and infer a latch.
        state_d         = state_q;
        cpu_ui_d        = cpu_ui_q;
        cur_addr_d      = cur_addr_q;
        opc_cnt_d       = opc_cnt_q;
        proto_err_d     = proto_err_q;
        fetch_count_d   = fetch_count_q;
        invalid_count_d = invalid_count_q;

        unique case (state_q)
            S_IDLE: begin
                cpu_ui_d = 8'h00;
                if (run) begin
                    state_d         = S_OPC;
                    cur_addr_d      = 6'd0;
                    cpu_ui_d        = mem_q[0][7:0];
                    opc_cnt_d       = 4'd0;
                    proto_err_d     = 1'b0;
                    fetch_count_d   = 8'h00;
                    invalid_count_d = 8'h00;
                end
            end
            S_OPC: begin
                if (req) begin
                    proto_err_d = 1'b1;
                end
                if (opc_cnt_q == OPC_LAST) begin
                    state_d  = S_IMM;
                    cpu_ui_d = mem_q[cur_addr_q][15:8];
                end else begin
                    opc_cnt_d = opc_cnt_q + 4'd1;
                end
            end
            S_IMM: begin
                // A request is counted even when run drops in the same cycle.
                if (req) begin
                    state_d = S_SETTLE;
                    if (fetch_count_q != 8'hFF) begin
                        fetch_count_d = fetch_count_q + 8'd1;
                    end
                    if (invalid_ins && (invalid_count_q != 8'hFF)) begin
                        invalid_count_d = invalid_count_q + 8'd1;
                    end
                end
            end
            S_SETTLE: begin
                cur_addr_d = pc;
                if (pc == halt_addr) begin
                    state_d  = S_HALT;
                    cpu_ui_d = 8'h00;
                end else begin
                    state_d   = S_OPC;
                    cpu_ui_d  = mem_q[pc][7:0];
                    opc_cnt_d = 4'd0;
                end
            end
            S_HALT: begin
                cpu_ui_d = 8'h00;
            end
            default: begin
                state_d  = S_IDLE;
                cpu_ui_d = 8'h00;
            end
        endcase

        if (!run) begin
            state_d    = S_IDLE;
            cpu_ui_d   = 8'h00;
            cur_addr_d = cur_addr_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cpu_ui_q        <= 8'h00;
            cur_addr_q      <= 6'd0;
            opc_cnt_q       <= 4'd0;
            send_ins_q      <= 1'b0;
            proto_err_q     <= 1'b0;
            fetch_count_q   <= 8'h00;
            invalid_count_q <= 8'h00;
        end else begin
            state_q         <= state_d;
            cpu_ui_q        <= cpu_ui_d;
            cur_addr_q      <= cur_addr_d;
            opc_cnt_q       <= opc_cnt_d;
            send_ins_q      <= send_ins;
            proto_err_q     <= proto_err_d;
            fetch_count_q   <= fetch_count_d;
            invalid_count_q <= invalid_count_d;
        end
    end

    assign cpu_ui        = cpu_ui_q;
    assign halted        = (state_q == S_HALT);
    assign proto_err     = proto_err_q;
    assign fetch_count   = fetch_count_q;
    assign invalid_count = invalid_count_q;
    assign cur_addr      = cur_addr_q;

endmodule

// File: tb/tb_cpu_program_feeder.sv
// Bench for cpu_program_feeder: directed literal checks plus randomized CPU
// behaviour compared every cycle against a timeline model of the feeder.
module tb_cpu_program_feeder;

    localparam int OPC = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_FEED = 1;
    localparam int PH_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  halt_addr = 6'd0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = 6'd0;
    logic [15:0] prog_data = 16'h0000;
    logic [7:0]  cpu_status = 8'h00;
    logic [7:0]  cpu_ui;
    logic        busy;
    logic        halted;
    logic        proto_err;
    logic [7:0]  fetch_count;
    logic [7:0]  invalid_count;
    logic [5:0]  cur_addr;

    cpu_program_feeder #(.OPC_CYCLES(OPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .halt_addr     (halt_addr),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .cpu_status    (cpu_status),
        .cpu_ui        (cpu_ui),
        .busy          (busy),
        .halted        (halted),
        .proto_err     (proto_err),
        .fetch_count   (fetch_count),
        .invalid_count (invalid_count),
        .cur_addr      (cur_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase, position within the current instruction's timeline, counts.
    int          m_phase;
    int          m_age;
    bit          m_settle;
    logic [5:0]  m_addr;
    logic [15:0] m_word;
    int          m_fetch;
    int          m_inv;
    bit          m_perr;
    bit          m_prev_send;
    logic [15:0] m_mem [64];

    task automatic model_reset();
        m_phase     = PH_IDLE;
        m_age       = 0;
        m_settle    = 1'b0;
        m_addr      = 6'd0;
        m_word      = 16'h0000;
        m_fetch     = 0;
        m_inv       = 0;
        m_perr      = 1'b0;
        m_prev_send = 1'b0;
    endtask

    task automatic model_edge();
        bit req;
        bit feeding;
        bit in_opcode;
        req         = cpu_status[7] && !m_prev_send;
        m_prev_send = cpu_status[7];
        feeding     = (m_phase == PH_FEED);
        in_opcode   = feeding && !m_settle && (m_age < OPC);
        if (feeding && !m_settle && !in_opcode && req) begin
            if (m_fetch < 255) m_fetch++;
            if (cpu_status[6] && m_inv < 255) m_inv++;
        end
        if (in_opcode && req) m_perr = 1'b1;
        if (!run) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_IDLE) begin
            m_phase  = PH_FEED;
            m_addr   = 6'd0;
            m_word   = m_mem[0];
            m_age    = 0;
            m_settle = 1'b0;
            m_fetch  = 0;
            m_inv    = 0;
            m_perr   = 1'b0;
        end else if (feeding) begin
            if (m_settle) begin
                m_addr = cpu_status[5:0];
                if (m_addr == halt_addr) begin
                    m_phase = PH_HALT;
                end else begin
                    m_word   = m_mem[m_addr];
                    m_age    = 0;
                    m_settle = 1'b0;
                end
            end else if (m_age < OPC) begin
                m_age++;
            end else if (req) begin
                m_settle = 1'b1;
            end
        end
        if (prog_we && !feeding) m_mem[prog_addr] = prog_data;
    endtask

    function automatic logic [7:0] exp_ui();
        if (m_phase != PH_FEED) return 8'h00;
        if (m_settle || m_age >= OPC) return m_word[15:8];
        return m_word[7:0];
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_edge();
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cpu_ui", 32'(cpu_ui), 32'(exp_ui()));
            check("busy", 32'(busy), 32'(m_phase == PH_FEED));
            check("halted", 32'(halted), 32'(m_phase == PH_HALT));
            check("proto_err", 32'(proto_err), 32'(m_perr));
            check("fetch_count", 32'(fetch_count), 32'(m_fetch));
            check("invalid_count", 32'(invalid_count), 32'(m_inv));
            check("cur_addr", 32'(cur_addr), 32'(m_addr));
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst cpu_ui", 32'(cpu_ui), 32'h00);
        check("rst busy", 32'(busy), 32'h0);
        check("rst halted", 32'(halted), 32'h0);
        check("rst proto_err", 32'(proto_err), 32'h0);
        check("rst fetch_count", 32'(fetch_count), 32'h00);
        check("rst invalid_count", 32'(invalid_count), 32'h00);
        check("rst cur_addr", 32'(cur_addr), 32'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = (i == 0) ? 16'h0A12 : (i == 5) ? 16'h3344 : 16'($urandom);
        end
        @(negedge clk);
        prog_we   = 1'b0;
        halt_addr = 6'd7;
        run       = 1'b1;

        // Opcode window then immediate, request, settle, next opcode.
        @(negedge clk);
        check("start opcode", 32'(cpu_ui), 32'h12);
        check("start busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("opcode held", 32'(cpu_ui), 32'h12);
        @(negedge clk);
        check("immediate", 32'(cpu_ui), 32'h0A);
        cpu_status = 8'h80;
        @(negedge clk);
        check("settle fetch_count", 32'(fetch_count), 32'h01);
        check("settle holds imm", 32'(cpu_ui), 32'h0A);
        cpu_status = 8'h05;
        @(negedge clk);
        check("next opcode", 32'(cpu_ui), 32'h44);
        check("next cur_addr", 32'(cur_addr), 32'h05);
        @(negedge clk);
        @(negedge clk);
        check("next immediate", 32'(cpu_ui), 32'h33);
        cpu_status = 8'hC0;
        @(negedge clk);
        cpu_status = 8'h07;
        check("invalid_count", 32'(invalid_count), 32'h01);
        @(negedge clk);
        check("halted", 32'(halted), 32'h1);
        check("halt cpu_ui", 32'(cpu_ui), 32'h00);
        check("halt busy", 32'(busy), 32'h0);
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = 16'hBEEF;
        @(negedge clk);
        prog_we = 1'b0;
        run     = 1'b0;
        @(negedge clk);
        check("idle not halted", 32'(halted), 32'h0);
        run = 1'b1;
        @(negedge clk);
        check("write in halt accepted", 32'(cpu_ui), 32'hEF);
        check("counters cleared", 32'(fetch_count), 32'h00);
        cpu_status = 8'h80;
        prog_we    = 1'b1;
        prog_data  = 16'h1111;
        @(negedge clk);
        check("proto_err set", 32'(proto_err), 32'h1);
        check("opc req not counted", 32'(fetch_count), 32'h00);
        cpu_status = 8'h00;
        prog_we    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy write dropped imm", 32'(cpu_ui), 32'hBE);
        cpu_status = 8'h80;
        run        = 1'b0;
        @(negedge clk);
        check("run drop idle", 32'(busy), 32'h0);
        check("run drop cpu_ui", 32'(cpu_ui), 32'h00);
        check("run drop req counted", 32'(fetch_count), 32'h01);
        cpu_status = 8'h00;
        run        = 1'b1;
        @(negedge clk);
        check("busy write dropped op", 32'(cpu_ui), 32'hEF);

        // Asynchronous reset while waiting in the immediate phase.
        @(negedge clk);
        @(negedge clk);
        cpu_status = 8'h80;
        @(negedge clk);
        cpu_status = 8'h01;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async cpu_ui", 32'(cpu_ui), 32'h00);
        check("async busy", 32'(busy), 32'h0);
        check("async fetch_count", 32'(fetch_count), 32'h00);
        check("async cur_addr", 32'(cur_addr), 32'h00);
        run        = 1'b0;
        cpu_status = 8'h00;
        @(negedge clk);
        rst_n     = 1'b1;
        halt_addr = 6'd63;
        @(negedge clk);
        run = 1'b1;

        // 300 back-to-back invalid requests saturate both counters.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            cpu_status = 8'hC1;
            @(negedge clk);
            cpu_status = 8'h01;
        end
        @(negedge clk);
        check("fetch_count saturates", 32'(fetch_count), 32'hFF);
        check("invalid_count saturates", 32'(invalid_count), 32'hFF);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            run        = ($urandom_range(99) < 97);
            cpu_status = {($urandom_range(99) < 35), ($urandom_range(99) < 25), 6'($urandom)};
            prog_we    = ($urandom_range(99) < 8);
            prog_addr  = 6'($urandom);
            prog_data  = 16'($urandom);
            if (c % 200 == 0) halt_addr = 6'($urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_program_feeder.md
# cpu_program_feeder

Host-side responder for the 8-bit CPU's instruction-fetch interface. Holds a 64-entry program memory loaded by a host, drives opcode and immediate bytes onto the CPU's `ui_in` bus, and watches the CPU's `uio_out` status byte `{send_ins, invalid_ins, pc[5:0]}` to learn when to advance and from which address. It sits on the test/board side of the CPU pins, replacing a human or external MCU feeding instructions by hand.

## Interface
Parameters:
- `OPC_CYCLES`, default 2: cycles the opcode byte is held before the immediate byte is presented; legal range 1–15.

Ports:
- `clk`  in  1  system clock, same clock as the CPU.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = feed program, 0 = stop and return to IDLE.
- `halt_addr`  in  6  pc value at which feeding stops.
- `prog_we`  in  1  program memory write strobe.
- `prog_addr`  in  6  program memory write address.
- `prog_data`  in  16  `{immediate[15:8], opcode[7:0]}`.
- `cpu_status`  in  8  CPU `uio_out`: bit7 `send_ins`, bit6 `invalid_ins`, bits[5:0] pc.
- `cpu_ui`  out  8  byte driven to CPU `ui_in`, registered.
- `busy`  out  1  1 in OPC, IMM, SETTLE.
- `halted`  out  1  1 in HALT.
- `proto_err`  out  1  sticky request-during-opcode flag.
- `fetch_count`  out  8  requests serviced, saturating at 255.
- `invalid_count`  out  8  requests with `invalid_ins`=1, saturating at 255.
- `cur_addr`  out  6  address currently being fed.

## Operation
- Program memory: 64×16, no reset. Writes are accepted only when `busy`=0. A `prog_we` while `busy`=1 is dropped silently.
- Request detect: `req = send_ins & ~send_ins_d`. `send_ins_d` is a register reset to 0. A multi-cycle `send_ins` high counts as one request.
- States: IDLE, OPC, IMM, SETTLE, HALT.
- IDLE: `cpu_ui`=0.
  - `run`=1 → OPC, `cur_addr`=0, `cpu_ui`←mem[0][7:0].
  - Counters and `proto_err` clear on that transition.
- OPC: hold the opcode for `OPC_CYCLES` cycles, then `cpu_ui`←mem[`cur_addr`][15:8] → IMM.
  - A `req` seen in OPC sets `proto_err` and is otherwise ignored.
- IMM: hold the immediate until `req`. On `req`:
  - `fetch_count`+1.
  - `invalid_count`+1 if `invalid_ins`=1 in the same cycle.
  - → SETTLE.
- SETTLE: exactly one cycle, which lets the CPU pc update. At the end of SETTLE, sample `p = cpu_status[5:0]`, set `cur_addr`←p, then:
  - if p == `halt_addr` → HALT, `cpu_ui`←0;
  - else → OPC, `cpu_ui`←mem[p][7:0].
- HALT: `cpu_ui`=0, `halted`=1. Stays until `run`=0.
- `run`=0 in any state → IDLE on the next edge, `cpu_ui`←0. `run` has priority over `req`.
- Invalid-instruction requests are serviced identically to normal ones; the CPU has already advanced its pc.
- pc wrap 63→0 is not special; memory index wraps naturally.

## Timing
- Reset (async, asserted): state IDLE, `cpu_ui`=0, `cur_addr`=0, counters 0, `busy`=0, `halted`=0, `proto_err`=0.
- Start latency: `run` sampled at edge E; opcode of mem[0] visible on `cpu_ui` after E.
- Opcode window: exactly `OPC_CYCLES` cycles. The immediate appears on the next edge.
- Request to next opcode: `req` in cycle R.
  - SETTLE occupies R+1.
  - The new opcode is driven after the edge ending R+1, i.e. visible in R+2.
- Counters update on the edge ending cycle R.
- Simultaneous `req` and `run` falling: go to IDLE, but the request is still counted.
- A memory write to the address being fed while `busy`=0 takes effect on the next start.

## Test plan
- Reset mid-run (`rst_n` low while in IMM) -> `cpu_ui`=0, state IDLE, counters 0 immediately (async), with no edge needed.
- Load mem[0]=16'h0A12, `run`=1, `OPC_CYCLES`=2 -> `cpu_ui`=8'h12 for 2 cycles, then 8'h0A held. `busy`=1.
- In IMM, pulse `send_ins` 1 cycle, pc=5 from the next cycle, mem[5]=16'h3344 -> SETTLE 1 cycle, `cpu_ui`=8'h44, `fetch_count`=1, `cur_addr`=5.
- Request with `invalid_ins`=1 and pc=7, `halt_addr`=7 -> `invalid_count`=1, `halted`=1, `cpu_ui`=0. `prog_we` is then accepted.
- `send_ins` pulse during OPC -> `proto_err`=1, `fetch_count` unchanged. Separately, `prog_we` while `busy`=1 -> memory unchanged (readback on next run).
- 300 serviced requests -> `fetch_count` saturates at 255.
